d_fifo_out_arbiter: RTL and testbench

//  Drain stage directly downstream of the D0/D1 destination FIFOs.

---
 rtl/d_fifo_out_arbiter_if.sv | 40 ++++
 rtl/d_fifo_out_arbiter.sv | 136 +++++++++++++
 tb/tb_d_fifo_out_arbiter.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/d_fifo_out_arbiter_if.sv
// Bundle of signals between the D0/D1 destination FIFOs, the drain arbiter and
// the output stage.
//   master : arbiter side. Takes in the FIFO flags/data and pause_out. Drives the
//            read strobes and the serialized word stream.
//   slave  : environment side (FIFOs plus output stage), mirror of master.
interface d_fifo_out_arbiter_if #(
  parameter int unsigned data_width = 6
) ();

  logic                  empty_D0;
  logic                  almost_empty_D0;
  logic [data_width-1:0] data_in_D0;
  logic                  empty_D1;
  logic                  almost_empty_D1;
  logic [data_width-1:0] data_in_D1;
  logic                  pause_out;
  logic                  rd_enable_D0;
  logic                  rd_enable_D1;
  logic [data_width-1:0] data_out;
  logic                  valid_out;
  logic                  sel_out;
  logic                  busy_out;

  modport master (
    input  empty_D0, almost_empty_D0, data_in_D0,
    input  empty_D1, almost_empty_D1, data_in_D1,
    input  pause_out,
    output rd_enable_D0, rd_enable_D1,
    output data_out, valid_out, sel_out, busy_out
  );

  modport slave (
    output empty_D0, almost_empty_D0, data_in_D0,
    output empty_D1, almost_empty_D1, data_in_D1,
    output pause_out,
    input  rd_enable_D0, rd_enable_D1,
    input  data_out, valid_out, sel_out, busy_out
  );

endinterface

// File: rtl/d_fifo_out_arbiter.sv
// Drain stage behind the D0/D1 destination FIFOs. Round-robin arbitration with a
// bounded burst per grant. It issues read strobes and realigns the FIFOs'
// registered read data into one word stream tagged with valid and source.
// Ports:
//   clk   : rising-edge clock, shared with the FIFOs
//   reset : synchronous, active-high
//   bus   : d_fifo_out_arbiter_if.master
//           in  : empty/almost_empty/data_in for D0 and D1, pause_out
//           out : rd_enable_D0/D1 (combinational), data_out/valid_out/sel_out
//                 (registered), busy_out
module d_fifo_out_arbiter #(
  parameter int unsigned data_width  = 6,
  parameter int unsigned max_burst   = 4,
  parameter int unsigned burst_width = 2
) (
  input logic                  clk,
  input logic                  reset,
  d_fifo_out_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StServeD0, StServeD1} state_e;

  state_e                 state_q, state_d;
  logic [burst_width-1:0] burst_cnt_q, burst_cnt_d;
  logic                   last_served_q, last_served_d;
  // Tag of the read issued last cycle; its data is on data_in_Dx this cycle.
  logic                   pend_valid_q, pend_valid_d;
  logic                   pend_sel_q, pend_sel_d;
  logic [data_width-1:0]  data_out_q, data_out_d;
  logic                   valid_out_q, valid_out_d;
  logic                   sel_out_q, sel_out_d;

  logic   rd0, rd1;
  logic   cur_sel, cur_rd, cur_empty, cur_ae, oth_empty, cnt_last;
  state_e oth_state;

  // Gated by reset so no word leaves a FIFO that is being cleared.
  assign rd0 = (state_q == StServeD0) & ~bus.empty_D0 & ~bus.pause_out & ~reset;
  assign rd1 = (state_q == StServeD1) & ~bus.empty_D1 & ~bus.pause_out & ~reset;

  // View of the currently granted FIFO and of the other one.
  assign cur_sel   = (state_q == StServeD1);
  assign cur_rd    = cur_sel ? rd1 : rd0;
  assign cur_empty = cur_sel ? bus.empty_D1 : bus.empty_D0;
  assign cur_ae    = cur_sel ? bus.almost_empty_D1 : bus.almost_empty_D0;
  assign oth_empty = cur_sel ? bus.empty_D0 : bus.empty_D1;
  assign oth_state = cur_sel ? StServeD0 : StServeD1;
  assign cnt_last  = (burst_cnt_q == burst_width'(max_burst - 1));

  always_comb begin
    state_d       = state_q;
    burst_cnt_d   = burst_cnt_q;
    last_served_d = last_served_q;
    case (state_q)
      StIdle: begin
        burst_cnt_d = '0;
        if (!bus.pause_out) begin
          if (!bus.empty_D0 && !bus.empty_D1) begin
            state_d = last_served_q ? StServeD0 : StServeD1;
          end else if (!bus.empty_D0) begin
            state_d = StServeD0;
          end else if (!bus.empty_D1) begin
            state_d = StServeD1;
          end
        end
      end
      StServeD0, StServeD1: begin
        if (cur_rd) begin
          last_served_d = cur_sel;
          if (!oth_empty && (cnt_last || cur_ae)) begin
            state_d     = oth_state;
            burst_cnt_d = '0;
          end else if (cur_ae) begin
            state_d     = StIdle;
            burst_cnt_d = '0;
          end else if (cnt_last) begin
            // Other side idle: start a fresh burst on the same FIFO.
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + burst_width'(1);
          end
        end else if (cur_empty) begin
          state_d     = oth_empty ? StIdle : oth_state;
          burst_cnt_d = '0;
        end
        // Paused with data waiting: hold state and burst count.
      end
      default: begin
        state_d     = StIdle;
        burst_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    pend_valid_d = rd0 | rd1;
    pend_sel_d   = rd1;
    valid_out_d  = pend_valid_q;
    data_out_d   = '0;
    sel_out_d    = sel_out_q;
    if (pend_valid_q) begin
      data_out_d = pend_sel_q ? bus.data_in_D1 : bus.data_in_D0;
      sel_out_d  = pend_sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      burst_cnt_q   <= '0;
      last_served_q <= 1'b1;
      pend_valid_q  <= 1'b0;
      pend_sel_q    <= 1'b0;
      data_out_q    <= '0;
      valid_out_q   <= 1'b0;
      sel_out_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      burst_cnt_q   <= burst_cnt_d;
      last_served_q <= last_served_d;
      pend_valid_q  <= pend_valid_d;
      pend_sel_q    <= pend_sel_d;
      data_out_q    <= data_out_d;
      valid_out_q   <= valid_out_d;
      sel_out_q     <= sel_out_d;
    end
  end

  assign bus.rd_enable_D0 = rd0;
  assign bus.rd_enable_D1 = rd1;
  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_out_q;
  assign bus.sel_out      = sel_out_q;
  assign bus.busy_out     = (state_q != StIdle) | pend_valid_q;

endmodule

// File: tb/tb_d_fifo_out_arbiter.sv
// Bench for d_fifo_out_arbiter. It contains a model of the two destination FIFOs
// (registered read data), a monitor that logs strobes and output words, and
// tasks for the individual scenarios.
module tb_d_fifo_out_arbiter;

  localparam int unsigned DW = 6;
  localparam int MaxBurst = 4;

  logic clk = 1'b0;
  logic reset;
  logic fifo_clr;
  always #5 clk = ~clk;

  d_fifo_out_arbiter_if #(.data_width(DW)) bus ();

  d_fifo_out_arbiter #(.data_width(DW), .max_burst(4), .burst_width(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;

  // ---------------- FIFO model ----------------
  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] mem1 [256];
  logic [7:0]    wp0, rp0, wp1, rp1;
  logic [DW-1:0] dreg0, dreg1;
  logic          wr0, wr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [7:0]    cnt0, cnt1;

  assign cnt0 = wp0 - rp0;
  assign cnt1 = wp1 - rp1;
  assign bus.empty_D0        = (cnt0 == 8'd0);
  assign bus.almost_empty_D0 = (cnt0 == 8'd1);
  assign bus.data_in_D0      = dreg0;
  assign bus.empty_D1        = (cnt1 == 8'd0);
  assign bus.almost_empty_D1 = (cnt1 == 8'd1);
  assign bus.data_in_D1      = dreg1;

  always @(posedge clk) begin
    if (fifo_clr) begin
      wp0 <= '0; rp0 <= '0; dreg0 <= '0;
      wp1 <= '0; rp1 <= '0; dreg1 <= '0;
    end else begin
      if (wr0) begin mem0[wp0] <= wdata0; wp0 <= wp0 + 8'd1; end
      if (wr1) begin mem1[wp1] <= wdata1; wp1 <= wp1 + 8'd1; end
      if (bus.rd_enable_D0) begin dreg0 <= mem0[rp0]; rp0 <= rp0 + 8'd1; end
      if (bus.rd_enable_D1) begin dreg1 <= mem1[rp1]; rp1 <= rp1 + 8'd1; end
    end
  end

  // ---------------- monitor / logs ----------------
  int unsigned   cyc = 0;
  bit            mon_en = 0;
  int            viol = 0;
  int            lat_err = 0;
  logic          p1_str = 0, p1_src = 0, p1_rst = 0, p2_str = 0, p2_src = 0;
  logic          mon_exp_v;
  logic [DW-1:0] wq0[$], wq1[$], oq0[$], oq1[$];
  bit            osrc[$], ssrc[$], exp_src[$];
  int unsigned   ocyc[$], scyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if ((bus.rd_enable_D0 && bus.empty_D0) || (bus.rd_enable_D1 && bus.empty_D1) ||
          (bus.rd_enable_D0 && bus.rd_enable_D1) ||
          ((bus.rd_enable_D0 || bus.rd_enable_D1) && (bus.pause_out || reset)))
        viol++;
      if (bus.valid_out !== 1'b1 && bus.data_out !== '0) viol++;
      // A word strobed two cycles ago shows up now unless a reset hit in between.
      mon_exp_v = p2_str && !p1_rst;
      if (bus.valid_out !== mon_exp_v || (mon_exp_v && bus.sel_out !== p2_src)) lat_err++;
      if (bus.valid_out === 1'b1) begin
        if (bus.sel_out) oq1.push_back(bus.data_out);
        else oq0.push_back(bus.data_out);
        osrc.push_back(bus.sel_out);
        ocyc.push_back(cyc);
      end
      if (bus.rd_enable_D0 || bus.rd_enable_D1) begin
        ssrc.push_back(bus.rd_enable_D1);
        scyc.push_back(cyc);
      end
      p2_str = p1_str;
      p2_src = p1_src;
      p1_str = bus.rd_enable_D0 | bus.rd_enable_D1;
      p1_src = bus.rd_enable_D1;
      p1_rst = reset;
    end
  end

  // ---------------- helpers (stimulus / bookkeeping only) ----------------
  task automatic clear_logs();
    wq0.delete(); wq1.delete(); oq0.delete(); oq1.delete();
    osrc.delete(); ssrc.delete(); ocyc.delete(); scyc.delete(); exp_src.delete();
    viol = 0;
    lat_err = 0;
  endtask

  task automatic hard_reset(input logic hold_pause);
    bus.pause_out = hold_pause;
    wr0 = 1'b0; wr1 = 1'b0;
    reset = 1'b1; fifo_clr = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; fifo_clr = 1'b0;
    clear_logs();
  endtask

  task automatic preload(input int n0, input int n1);
    for (int i = 0; i < ((n0 > n1) ? n0 : n1); i++) begin
      wr0 = (i < n0); wdata0 = DW'($urandom);
      wr1 = (i < n1); wdata1 = DW'($urandom);
      if (wr0) wq0.push_back(wdata0);
      if (wr1) wq1.push_back(wdata1);
      @(negedge clk);
    end
    wr0 = 1'b0; wr1 = 1'b0;
  endtask

  task automatic drain(output bit timed_out);
    int n = 0;
    timed_out = 1'b0;
    while (!(bus.empty_D0 && bus.empty_D1 && !bus.busy_out)) begin
      @(negedge clk);
      n++;
      if (n > 600) begin timed_out = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  // Index of first difference between delivered and written words, -2 on length.
  function automatic int seq_diff(input bit src);
    int r = -1;
    if (src == 1'b0) begin
      if (oq0.size() != wq0.size()) r = -2;
      else foreach (wq0[i]) if (r == -1 && oq0[i] !== wq0[i]) r = i;
    end else begin
      if (oq1.size() != wq1.size()) r = -2;
      else foreach (wq1[i]) if (r == -1 && oq1[i] !== wq1[i]) r = i;
    end
    return r;
  endfunction

  function automatic int order_diff();
    int r = -1;
    if (osrc.size() != exp_src.size()) r = -2;
    else foreach (exp_src[i]) if (r == -1 && osrc[i] !== exp_src[i]) r = i;
    return r;
  endfunction

  // Source order for preloaded FIFOs with no further writes, starting from D0
  // priority: a grant takes up to MaxBurst words while the other side has data,
  // otherwise everything that is left, then hands over.
  task automatic build_order(input int n0, input int n1);
    int n[2];
    int cur;
    int k;
    n[0] = n0; n[1] = n1;
    exp_src.delete();
    cur = (n0 > 0) ? 0 : 1;
    while (n[0] + n[1] > 0) begin
      if (n[1-cur] > 0) k = (n[cur] < MaxBurst) ? n[cur] : MaxBurst;
      else k = n[cur];
      repeat (k) exp_src.push_back(bit'(cur));
      n[cur] -= k;
      cur = 1 - cur;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bit to;
    bit seen;
    int n;
    clear_logs();
    reset = 1'b1;
    preload(3, 3);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (bus.rd_enable_D0 !== 1'b0 || bus.rd_enable_D1 !== 1'b0) begin
        bad++;
        $display("FAIL reset_no_strobe got=%b%b want=00", bus.rd_enable_D0, bus.rd_enable_D1);
      end
    end
    total++;
    if (bus.data_out !== '0 || bus.valid_out !== 1'b0 || bus.sel_out !== 1'b0 ||
        bus.busy_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%h/%b/%b/%b want=0/0/0/0", bus.data_out, bus.valid_out,
               bus.sel_out, bus.busy_out);
    end
    reset = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < 6) begin
      @(negedge clk);
      n++;
      if (bus.rd_enable_D0 || bus.rd_enable_D1) begin
        seen = 1'b1;
        total++;
        if (bus.rd_enable_D0 !== 1'b1) begin
          bad++;
          $display("FAIL reset_first_grant got=D%0d want=D0", bus.rd_enable_D1);
        end
      end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL reset_grant_timeout got=none want=strobe"); end
    drain(to);
    build_order(3, 3);
    total++;
    if (to) begin bad++; $display("FAIL reset_drain got=timeout want=idle"); end
    total++;
    if (order_diff() != -1) begin
      bad++; $display("FAIL reset_order got=%0d want=-1", order_diff());
    end
    total++;
    if (seq_diff(0) != -1 || seq_diff(1) != -1) begin
      bad++; $display("FAIL reset_data got=%0d,%0d want=-1,-1", seq_diff(0), seq_diff(1));
    end
  endtask

  task automatic test_single();
    bit to;
    bit ok;
    hard_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      wr0 = 1'b1; wdata0 = DW'(5 + i); wq0.push_back(wdata0);
      @(negedge clk);
    end
    wr0 = 1'b0;
    bus.pause_out = 1'b0;
    drain(to);
    total++;
    if (to) begin bad++; $display("FAIL single_drain got=timeout want=idle"); end
    ok = (scyc.size() == 3);
    if (ok) ok = !ssrc[0] && !ssrc[1] && !ssrc[2] &&
                 scyc[1] == scyc[0] + 1 && scyc[2] == scyc[0] + 2;
    total++;
    if (!ok) begin
      bad++; $display("FAIL single_strobes got=%0d strobes want=3 consecutive D0", scyc.size());
    end
    ok = (ocyc.size() == 3) && (scyc.size() == 3);
    if (ok) foreach (ocyc[i]) if (ocyc[i] != scyc[i] + 2) ok = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL single_latency got=%0d words want=3 at +2", ocyc.size()); end
    total++;
    if (seq_diff(0) != -1 || oq1.size() != 0) begin
      bad++; $display("FAIL single_data got=%0d,%0d want=-1,0", seq_diff(0), oq1.size());
    end
    total++;
    if (bus.busy_out !== 1'b0 || bus.valid_out !== 1'b0 || bus.sel_out !== 1'b0) begin
      bad++;
      $display("FAIL single_idle got=%b/%b/%b want=0/0/0", bus.busy_out, bus.valid_out,
               bus.sel_out);
    end
  endtask

  task automatic test_fairness();
    bit to;
    hard_reset(1'b1);
    preload(6, 6);
    bus.pause_out = 1'b0;
    drain(to);
    exp_src.delete();
    repeat (4) exp_src.push_back(1'b0);
    repeat (4) exp_src.push_back(1'b1);
    repeat (2) exp_src.push_back(1'b0);
    repeat (2) exp_src.push_back(1'b1);
    total++;
    if (to) begin bad++; $display("FAIL fair_drain got=timeout want=idle"); end
    total++;
    if (order_diff() != -1) begin bad++; $display("FAIL fair_order got=%0d want=-1", order_diff()); end
    total++;
    if (ocyc.size() != 12 || ocyc[ocyc.size()-1] - ocyc[0] != 11) begin
      bad++; $display("FAIL fair_gapless got=%0d words want=12 back-to-back", ocyc.size());
    end
    total++;
    if (seq_diff(0) != -1 || seq_diff(1) != -1) begin
      bad++; $display("FAIL fair_data got=%0d,%0d want=-1,-1", seq_diff(0), seq_diff(1));
    end
  endtask

  task automatic test_backpressure();
    bit to;
    bit stray;
    int seen;
    int n;
    int late;
    int unsigned pc;
    hard_reset(1'b1);
    preload(6, 6);
    bus.pause_out = 1'b0;
    seen = 0; n = 0;
    while (seen < 2 && n < 20) begin
      @(negedge clk);
      if (bus.rd_enable_D0) seen++;
      n++;
    end
    total++;
    if (seen != 2) begin bad++; $display("FAIL bp_start got=%0d want=2", seen); end
    bus.pause_out = 1'b1;
    pc = cyc + 1;
    stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.rd_enable_D0 || bus.rd_enable_D1) stray = 1'b1;
    end
    bus.pause_out = 1'b0;
    total++;
    if (stray) begin bad++; $display("FAIL bp_strobe_in_pause got=1 want=0"); end
    drain(to);
    late = 0;
    foreach (ocyc[i]) if (ocyc[i] >= pc && ocyc[i] <= pc + 4) late++;
    total++;
    if (late > 2) begin bad++; $display("FAIL bp_inflight got=%0d want<=2", late); end
    exp_src.delete();
    repeat (4) exp_src.push_back(1'b0);
    repeat (4) exp_src.push_back(1'b1);
    repeat (2) exp_src.push_back(1'b0);
    repeat (2) exp_src.push_back(1'b1);
    total++;
    if (to || order_diff() != -1) begin
      bad++; $display("FAIL bp_order got=%0d to=%b want=-1", order_diff(), to);
    end
    total++;
    if (seq_diff(0) != -1 || seq_diff(1) != -1) begin
      bad++; $display("FAIL bp_data got=%0d,%0d want=-1,-1", seq_diff(0), seq_diff(1));
    end
  endtask

  task automatic test_empty_guard();
    bit to;
    bit guard_bad;
    hard_reset(1'b0);
    guard_bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.rd_enable_D1 && bus.empty_D1) guard_bad = 1'b1;
      wr1 = ($urandom_range(0, 3) != 0); wdata1 = DW'($urandom);
      if (wr1) wq1.push_back(wdata1);
      @(negedge clk);
    end
    wr1 = 1'b0;
    drain(to);
    total++;
    if (guard_bad || viol != 0) begin
      bad++; $display("FAIL guard_empty_read got=%0d want=0", viol + int'(guard_bad));
    end
    total++;
    if (to || seq_diff(1) != -1 || oq0.size() != 0) begin
      bad++; $display("FAIL guard_data got=%0d to=%b want=-1", seq_diff(1), to);
    end
    total++;
    if (lat_err != 0) begin bad++; $display("FAIL guard_latency got=%0d want=0", lat_err); end
  endtask

  task automatic test_random_preload();
    bit to;
    int n0, n1;
    for (int it = 0; it < 4; it++) begin
      hard_reset(1'b1);
      n0 = $urandom_range(1, 10);
      n1 = $urandom_range(0, 10);
      preload(n0, n1);
      bus.pause_out = 1'b0;
      drain(to);
      build_order(n0, n1);
      total++;
      if (to || order_diff() != -1) begin
        bad++; $display("FAIL rpre_order n0=%0d n1=%0d got=%0d want=-1", n0, n1, order_diff());
      end
      total++;
      if (ocyc.size() != n0 + n1 || ocyc[ocyc.size()-1] - ocyc[0] != n0 + n1 - 1) begin
        bad++; $display("FAIL rpre_gapless got=%0d words want=%0d", ocyc.size(), n0 + n1);
      end
    end
  endtask

  task automatic test_random();
    bit to;
    hard_reset(1'b0);
    for (int c = 0; c < 300; c++) begin
      wr0 = ($urandom_range(0, 2) == 0); wdata0 = DW'($urandom);
      wr1 = ($urandom_range(0, 1) == 0); wdata1 = DW'($urandom);
      if (wr0) wq0.push_back(wdata0);
      if (wr1) wq1.push_back(wdata1);
      bus.pause_out = ($urandom_range(0, 5) == 0);
      @(negedge clk);
    end
    wr0 = 1'b0; wr1 = 1'b0; bus.pause_out = 1'b0;
    drain(to);
    total++;
    if (to) begin bad++; $display("FAIL rand_drain got=timeout want=idle"); end
    total++;
    if (seq_diff(0) != -1 || seq_diff(1) != -1) begin
      bad++; $display("FAIL rand_data got=%0d,%0d want=-1,-1", seq_diff(0), seq_diff(1));
    end
    total++;
    if (viol != 0 || lat_err != 0) begin
      bad++; $display("FAIL rand_protocol got=%0d/%0d want=0/0", viol, lat_err);
    end
  endtask

  task automatic test_mid_reset();
    bit seen;
    int n;
    hard_reset(1'b1);
    preload(0, 6);
    bus.pause_out = 1'b0;
    seen = 1'b0; n = 0;
    while (!seen && n < 10) begin
      @(negedge clk);
      seen = bus.rd_enable_D1;
      n++;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL mreset_serve got=none want=D1 strobe"); end
    reset = 1'b1; fifo_clr = 1'b1;
    @(negedge clk);
    reset = 1'b0; fifo_clr = 1'b0;
    @(negedge clk);
    total++;
    if (bus.valid_out !== 1'b0 || bus.busy_out !== 1'b0 || bus.data_out !== '0) begin
      bad++;
      $display("FAIL mreset_after got=%b/%b/%h want=0/0/0", bus.valid_out, bus.busy_out,
               bus.data_out);
    end
    repeat (4) @(negedge clk);
    total++;
    if (osrc.size() != 0) begin bad++; $display("FAIL mreset_dropped got=%0d want=0", osrc.size()); end
    total++;
    if (viol != 0 || lat_err != 0) begin
      bad++; $display("FAIL mreset_protocol got=%0d/%0d want=0/0", viol, lat_err);
    end
  endtask

  initial begin
    reset = 1'b1; fifo_clr = 1'b1; bus.pause_out = 1'b0;
    wr0 = 1'b0; wr1 = 1'b0; wdata0 = '0; wdata1 = '0;
    @(negedge clk);
    @(negedge clk);
    fifo_clr = 1'b0;
    mon_en = 1'b1;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_empty_guard();
    test_random_preload();
    test_random();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
